mmio_uart_tx: RTL and testbench
===============================

// Module: mmio_uart_tx
// PURPOSE
//  Memory-mapped UART transmitter on the core's M-stage store bus, alongside data memory.
//  Snoops MemWriteM/DataAdrM/WriteDataM. A store to TXDATA pushes its low byte into a small FIFO.
//  A serializer sends each byte as 8N1, LSB first. The top level muxes io_rdata into the load path.
// PARAMETERS
//  BASE_ADDR     32'h0000_FF00  word-aligned base; TXDATA at +0, STATUS at +4
//  CLKS_PER_BIT  16             clk cycles per UART bit, >=2
//  FIFO_DEPTH    8              entries, power of two, >=2
// PORTS
//  clk         in   1   core clock, rising edge
//  reset       in   1   asynchronous, active-low (asserted at 0), synchronous deassert external
//  MemWriteM   in   1   store strobe from core M stage
//  DataAdrM    in   32  M-stage byte address
//  WriteDataM  in   32  M-stage store data
//  io_rdata    out  32  STATUS when DataAdrM==BASE_ADDR+4, else 0 (combinational)
//  uart_tx     out  1   serial line, idle high, registered
//  tx_busy     out  1   FIFO non-empty or frame in progress
// BEHAVIOUR
//  Reset (async, reset==0):
//   - uart_tx=1, FIFO empty (rd/wr ptr=0, count=0), overflow=0, FSM=IDLE.
//   - bit/baud counters=0; tx_busy=0.
//  Decode: address match is full 32-bit equality; no byte-lane decode; accesses elsewhere ignored.
//  push = MemWriteM & DataAdrM==BASE_ADDR; data = WriteDataM[7:0]; written at the clock edge.
//  Full + push, no same-cycle pop: byte dropped; sticky overflow<=1.
//  Full + push with same-cycle pop: both happen; count unchanged; no overflow.
//  Store to STATUS with WriteDataM[3]==1 clears overflow. If an overflowing push coincides, set wins.
//  STATUS[0]=full, [1]=empty, [2]=frame active (FSM!=IDLE), [3]=overflow.
//  STATUS[7:4]=count, saturating at 15. [31:8]=0.
//  FSM IDLE->START->DATA->STOP->(IDLE | START); the baud counter counts 0..CLKS_PER_BIT-1 per bit.
//   - IDLE: if FIFO non-empty, pop into shift reg; next state START; uart_tx<=0.
//   - START: after CLKS_PER_BIT cycles -> DATA; uart_tx<=shift[0].
//   - DATA: 8 bits, each CLKS_PER_BIT cycles, shift right; after bit7 -> STOP; uart_tx<=1.
//   - STOP: after CLKS_PER_BIT cycles: if FIFO non-empty, pop and -> START (uart_tx<=0), else -> IDLE.
//   - Back-to-back frames have no idle gap.
//  Latency: a push at edge N into an empty, idle block drives uart_tx low from edge N+1.
//  Frame length is exactly 10*CLKS_PER_BIT cycles.
//  Push into an empty FIFO cannot pop in the same cycle; the pop uses the registered empty flag.
//  Pointers wrap modulo FIFO_DEPTH; count is 0..FIFO_DEPTH.
//  Reset asserted mid-frame: uart_tx goes high immediately, and FIFO contents are discarded.
//  Loads never alter state; io_rdata has no side effects.
// STRUCTURE
//  Shared header mmio_defs.vh:
//   - UART_BASE and the TXDATA/STATUS offsets
//   - STATUS bit positions (FULL, EMPTY, ACTIVE, OVF, CNT_LSB/MSB)
//   - FSM state encodings: IDLE=2'd0, START=1, DATA=2, STOP=3
//  Sub-module uart_tx_fifo (DEPTH, WIDTH=8):
//   - ports push/wdata/pop/rdata/full/empty/count
//   - implements the push/pop-when-full rule
//  Top body: address decode, overflow/status logic, serializer FSM, baud and bit counters.
// TESTING (CLKS_PER_BIT=4, FIFO_DEPTH=4)
//  1 Reset values: hold reset=0 mid-run -> uart_tx=1, tx_busy=0, io_rdata@+4 = 32'h0000_0002.
//  2 Single byte: store 32'hABCD_0055 to +0.
//    -> start bit one cycle later, then 1,0,1,0,1,0,1,0 and a stop bit, 4 cycles each.
//    -> tx_busy drops 40 cycles after uart_tx falls.
//  3 Overflow: 6 back-to-back stores while the first frame is active.
//    -> 1 byte in the shifter, 4 in the FIFO, 1 dropped; STATUS = 32'h0000_004D.
//    -> after writing 32'h8 to +4, bit3 = 0.
//  4 Full+pop: fill the FIFO, then store exactly on the STOP->START pop cycle.
//    -> accepted, overflow stays 0, all bytes sent in order.
//  5 Decode: stores to BASE+8 and BASE-4, and a load of +0.
//    -> no FIFO change; io_rdata=0 except at +4.
//  6 Async reset asserted mid-DATA bit3.
//    -> uart_tx=1 within the same cycle; the next store starts a clean frame.

Source files
------------

// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// STATUS layout and serializer state encodings.
package mmio_uart_tx_pkg;

  // Register offsets from the block base address
  localparam logic [31:0] TXDATA_OFF = 32'h0000_0000;
  localparam logic [31:0] STATUS_OFF = 32'h0000_0004;

  // STATUS bit positions
  localparam int unsigned STAT_FULL_BIT    = 0;
  localparam int unsigned STAT_EMPTY_BIT   = 1;
  localparam int unsigned STAT_ACTIVE_BIT  = 2;
  localparam int unsigned STAT_OVF_BIT     = 3;
  localparam int unsigned STAT_CNT_LSB     = 4;
  localparam int unsigned STAT_CNT_MSB     = 7;

  // Serializer state encodings
  localparam int unsigned STATE_W = 2;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // STATUS register image as seen on the load path
  typedef struct packed {
    logic [23:0] rsvd;
    logic [3:0]  cnt;
    logic        ovf;
    logic        active;
    logic        empty;
    logic        full;
  } status_t;

  // Clamp a FIFO occupancy to the 4-bit STATUS count field
  function automatic logic [3:0] sat_cnt4(input logic [31:0] cnt);
    return (cnt > 32'd15) ? 4'hF : cnt[3:0];
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART serializer. A push while full is accepted only
// when a pop happens in the same cycle; otherwise it is silently dropped and
// the caller is expected to flag the overflow.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // Accept/pop qualification and pointer/count next-state
  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are meaningless while empty so no reset is needed
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter snooping the M-stage store bus.
// TXDATA stores enqueue a byte; STATUS is readable and its overflow bit is
// write-one-to-clear.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_FF00,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic [31:0] DataAdrM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] io_rdata,
  output logic        uart_tx,
  output logic        tx_busy
);

  import mmio_uart_tx_pkg::*;

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [BAUD_W-1:0]  baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;

  logic               push;
  logic               push_ok;
  logic               status_hit;
  logic               status_wr;
  logic               baud_last;
  logic               fifo_pop;
  logic [7:0]         fifo_rdata;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic [CNT_W-1:0]   cnt_nxt;
  status_t            status;
  logic               unused_wdata;

  // Full 32-bit address decode of the two registers
  assign push       = MemWriteM & (DataAdrM == BASE_ADDR + TXDATA_OFF);
  assign status_hit = (DataAdrM == BASE_ADDR + STATUS_OFF);
  assign status_wr  = MemWriteM & status_hit;
  assign baud_last  = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
  assign unused_wdata = ^WriteDataM[31:8];

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (WriteDataM[7:0]),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Serializer next-state, line level, overflow and busy computation
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    ovf_d    = ovf_q;
    fifo_pop = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          state_d  = ST_START;
          tx_d     = 1'b0;
          baud_d   = '0;
        end
      end
      ST_START: begin
        if (baud_last) begin
          state_d = ST_DATA;
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = '0;
          baud_d  = '0;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      ST_DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      ST_STOP: begin
        if (baud_last) begin
          baud_d = '0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
            state_d  = ST_START;
            tx_d     = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Overflow: a dropped push wins over a same-cycle clear
    if (push & fifo_full & ~fifo_pop) begin
      ovf_d = 1'b1;
    end else if (status_wr & WriteDataM[STAT_OVF_BIT]) begin
      ovf_d = 1'b0;
    end

    // Busy reflects next-cycle FIFO occupancy and frame activity
    push_ok = push & (~fifo_full | fifo_pop);
    cnt_nxt = fifo_count + CNT_W'(push_ok) - CNT_W'(fifo_pop);
    busy_d  = (cnt_nxt != '0) | (state_d != ST_IDLE);
  end

  // Serializer and control registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
    end
  end

  // STATUS image for the load path
  always_comb begin
    status        = '0;
    status.full   = fifo_full;
    status.empty  = fifo_empty;
    status.active = (state_q != ST_IDLE);
    status.ovf    = ovf_q;
    status.cnt    = sat_cnt4(32'(fifo_count));
  end

  assign io_rdata = status_hit ? status : 32'h0;
  assign uart_tx  = tx_q;
  assign tx_busy  = busy_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'h0000_FF00;
  localparam logic [31:0] STAT = 32'h0000_FF04;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemWriteM = 1'b0;
  logic [31:0] DataAdrM = 32'h0;
  logic [31:0] WriteDataM = 32'h0;
  logic [31:0] io_rdata;
  logic        uart_tx;
  logic        tx_busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] rx_q[$];
  logic       mon_act = 1'b0;
  int         mon_cnt = 0;
  logic [7:0] mon_sh = 8'h0;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [31:0] exp_rdata;
    logic        exp_busy;
  } vec_t;

  vec_t vecs[8];

  mmio_uart_tx #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (4),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .MemWriteM  (MemWriteM),
    .DataAdrM   (DataAdrM),
    .WriteDataM (WriteDataM),
    .io_rdata   (io_rdata),
    .uart_tx    (uart_tx),
    .tx_busy    (tx_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one bus cycle; returns at the following falling edge
  task automatic drive(input logic we, input logic [31:0] adr, input logic [31:0] wd);
    MemWriteM = we;
    DataAdrM = adr;
    WriteDataM = wd;
    @(negedge clk);
  endtask

  task automatic bus_idle();
    MemWriteM = 1'b0;
    DataAdrM = 32'h0;
    WriteDataM = 32'h0;
  endtask

  task automatic wait_rx(input int n, input int budget);
    int k = 0;
    while (rx_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("rx_count", 32'(rx_q.size()), 32'(n));
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (tx_busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("idle_wait", {31'b0, tx_busy}, 32'h0);
  endtask

  task automatic chk_rx(input string name, input int idx, input logic [7:0] exp);
    logic [7:0] got;
    got = (idx < rx_q.size()) ? rx_q[idx] : 8'hxx;
    chk($sformatf("%s[%0d]", name, idx), {24'b0, got}, {24'b0, exp});
  endtask

  // Serial line monitor: mid-bit sampling of 8N1 frames at 4 clocks per bit
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        mon_act = 1'b0;
      end else if (!mon_act) begin
        if (uart_tx === 1'b0) begin
          mon_act = 1'b1;
          mon_cnt = 0;
        end
      end else begin
        mon_cnt++;
        if (mon_cnt >= 6 && mon_cnt <= 34 && (mon_cnt % 4) == 2)
          mon_sh = {uart_tx, mon_sh[7:1]};
        if (mon_cnt == 38) begin
          chk("stop_bit", {31'b0, uart_tx}, 32'h1);
          rx_q.push_back(mon_sh);
          mon_act = 1'b0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] frame;

    vecs[0] = '{1'b0, STAT,           32'h0,  32'h0000_0002, 1'b0};
    vecs[1] = '{1'b0, BASE,           32'h0,  32'h0000_0000, 1'b0};
    vecs[2] = '{1'b1, BASE + 32'h8,   32'h11, 32'h0000_0000, 1'b0};
    vecs[3] = '{1'b1, BASE - 32'h4,   32'h22, 32'h0000_0000, 1'b0};
    vecs[4] = '{1'b0, STAT,           32'h0,  32'h0000_0002, 1'b0};
    vecs[5] = '{1'b0, 32'h0000_0004,  32'h0,  32'h0000_0000, 1'b0};
    vecs[6] = '{1'b1, STAT,           32'h8,  32'h0000_0002, 1'b0};
    vecs[7] = '{1'b0, STAT,           32'h0,  32'h0000_0002, 1'b0};

    // Reset values
    repeat (3) @(negedge clk);
    DataAdrM = STAT;
    #1;
    chk("rst_uart_tx", {31'b0, uart_tx}, 32'h1);
    chk("rst_busy", {31'b0, tx_busy}, 32'h0);
    chk("rst_status", io_rdata, 32'h0000_0002);
    @(negedge clk);
    reset = 1'b1;
    bus_idle();
    @(negedge clk);

    // Decode vectors applied while idle
    for (int i = 0; i < 8; i++) begin
      MemWriteM = vecs[i].we;
      DataAdrM = vecs[i].adr;
      WriteDataM = vecs[i].wd;
      #1;
      chk($sformatf("vec%0d_rdata", i), io_rdata, vecs[i].exp_rdata);
      @(negedge clk);
      chk($sformatf("vec%0d_busy", i), {31'b0, tx_busy}, {31'b0, vecs[i].exp_busy});
    end
    bus_idle();
    chk("vec_no_rx", 32'(rx_q.size()), 32'h0);

    // Single byte: exact frame waveform and busy timing
    rx_q.delete();
    drive(1'b1, BASE, 32'hABCD_0055);
    bus_idle();
    chk("t2_pre_start", {31'b0, uart_tx}, 32'h1);
    chk("t2_busy_early", {31'b0, tx_busy}, 32'h1);
    frame = {1'b1, 8'h55, 1'b0};
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk($sformatf("t2_line%0d", i), {31'b0, uart_tx}, {31'b0, frame[i/4]});
    end
    chk("t2_busy_last", {31'b0, tx_busy}, 32'h1);
    @(negedge clk);
    chk("t2_busy_drop", {31'b0, tx_busy}, 32'h0);
    chk("t2_line_idle", {31'b0, uart_tx}, 32'h1);
    chk("t2_rx_n", 32'(rx_q.size()), 32'h1);
    chk_rx("t2_rx", 0, 8'h55);

    // Overflow: six back-to-back stores, one dropped, then W1C
    rx_q.delete();
    for (int i = 0; i < 6; i++) drive(1'b1, BASE, 32'h31 + 32'(i));
    bus_idle();
    DataAdrM = STAT;
    #1;
    chk("t3_status_ovf", io_rdata, 32'h0000_004D);
    drive(1'b1, STAT, 32'h8);
    bus_idle();
    DataAdrM = STAT;
    #1;
    chk("t3_status_clr", io_rdata, 32'h0000_0045);
    bus_idle();
    wait_rx(5, 400);
    for (int i = 0; i < 5; i++) chk_rx("t3_rx", i, 8'h31 + 8'(i));
    wait_idle(100);
    DataAdrM = STAT;
    #1;
    chk("t3_status_end", io_rdata, 32'h0000_0002);
    bus_idle();
    @(negedge clk);

    // Full FIFO with a push landing on the STOP->START pop edge
    rx_q.delete();
    for (int i = 0; i < 5; i++) drive(1'b1, BASE, 32'h41 + 32'(i));
    bus_idle();
    repeat (36) @(negedge clk);
    drive(1'b1, BASE, 32'h46);
    bus_idle();
    DataAdrM = STAT;
    #1;
    chk("t4_status", io_rdata, 32'h0000_0045);
    bus_idle();
    wait_rx(6, 400);
    for (int i = 0; i < 6; i++) chk_rx("t4_rx", i, 8'h41 + 8'(i));
    wait_idle(100);
    DataAdrM = STAT;
    #1;
    chk("t4_status_end", io_rdata, 32'h0000_0002);
    bus_idle();
    @(negedge clk);

    // Asynchronous reset in the middle of data bit 3
    rx_q.delete();
    drive(1'b1, BASE, 32'h00);
    drive(1'b1, BASE, 32'h77);
    bus_idle();
    repeat (17) @(negedge clk);
    chk("t6_bit3_low", {31'b0, uart_tx}, 32'h0);
    reset = 1'b0;
    #1;
    chk("t6_rst_line", {31'b0, uart_tx}, 32'h1);
    chk("t6_rst_busy", {31'b0, tx_busy}, 32'h0);
    DataAdrM = STAT;
    #1;
    chk("t6_rst_status", io_rdata, 32'h0000_0002);
    bus_idle();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_no_rx", 32'(rx_q.size()), 32'h0);
    drive(1'b1, BASE, 32'hA5);
    bus_idle();
    wait_rx(1, 100);
    chk_rx("t6_rx", 0, 8'hA5);
    repeat (60) @(negedge clk);
    chk("t6_rx_only_one", 32'(rx_q.size()), 32'h1);
    chk("t6_busy_end", {31'b0, tx_busy}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
